// File: rtl/branch_ctrl.sv
// Branch control stage: decodes JMP/JZ/CALL/RET/HALT and drives the PC counter's load port.
// Optional macro BRANCH_CTRL_JZ_EN enables opcode 010 as a conditional jump on zero_flag.
module branch_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] pc,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    input  logic       zero_flag,
    output logic       cnt_load,
    output logic [4:0] cnt_val,
    output logic       flush,
    output logic       halted,
    output logic       stack_ovf,
    output logic       stack_unf,
    output logic [3:0] sp
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] SP_FULL = 4'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_JMP  = 3'b001,
        OP_JZ   = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_HALT = 3'b101
    } opcode_e;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_HALT
    } state_e;

    state_e     state_q, state_d;
    logic       cnt_load_q, cnt_load_d;
    logic [4:0] cnt_val_q, cnt_val_d;
    logic       flush_q, flush_d;
    logic       halted_q, halted_d;
    logic       stack_ovf_q, stack_ovf_d;
    logic       stack_unf_q, stack_unf_d;
    logic [3:0] sp_q, sp_d;

    logic [4:0]    stack_q [DEPTH];
    logic          push_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [4:0]    ret_addr;
    logic [2:0]    opcode;
    logic [4:0]    target;
    logic          jz_taken;

`ifdef BRANCH_CTRL_JZ_EN
    assign jz_taken = zero_flag;
`else
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
    assign jz_taken         = 1'b0;
`endif

    assign opcode   = instr[7:5];
    assign target   = instr[4:0];
    assign ret_addr = pc + 5'd1;
    assign wr_idx   = AW'(sp_q);
    assign rd_idx   = AW'(sp_q - 4'd1);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_load_d  = 1'b0;
        cnt_val_d   = cnt_val_q;
        flush_d     = 1'b0;
        halted_d    = halted_q;
        stack_ovf_d = stack_ovf_q;
        stack_unf_d = stack_unf_q;
        sp_d        = sp_q;
        push_en     = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (instr_valid) begin
                    case (opcode)
                        OP_JMP: begin
                            cnt_load_d = 1'b1;
                            cnt_val_d  = target;
                            flush_d    = 1'b1;
                            state_d    = S_FLUSH;
                        end
                        OP_JZ: begin
                            if (jz_taken) begin
                                cnt_load_d = 1'b1;
                                cnt_val_d  = target;
                                flush_d    = 1'b1;
                                state_d    = S_FLUSH;
                            end
                        end
                        OP_CALL: begin
                            if (sp_q == SP_FULL) begin
                                stack_ovf_d = 1'b1;
                                halted_d    = 1'b1;
                                state_d     = S_HALT;
                            end else begin
                                push_en    = 1'b1;
                                sp_d       = sp_q + 4'd1;
                                cnt_load_d = 1'b1;
                                cnt_val_d  = target;
                                flush_d    = 1'b1;
                                state_d    = S_FLUSH;
                            end
                        end
                        OP_RET: begin
                            if (sp_q == 4'd0) begin
                                stack_unf_d = 1'b1;
                                halted_d    = 1'b1;
                                state_d     = S_HALT;
                            end else begin
                                sp_d       = sp_q - 4'd1;
                                cnt_load_d = 1'b1;
                                cnt_val_d  = stack_q[rd_idx];
                                flush_d    = 1'b1;
                                state_d    = S_FLUSH;
                            end
                        end
                        OP_HALT: begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                        default: ;
                    endcase
                end
            end
            // The fetched instruction at A+1 is discarded here; only the return to RUN happens.
            S_FLUSH: state_d = S_RUN;
            S_HALT:  ;
            default: state_d = S_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_RUN;
            cnt_load_q  <= 1'b0;
            cnt_val_q   <= 5'd0;
            flush_q     <= 1'b0;
            halted_q    <= 1'b0;
            stack_ovf_q <= 1'b0;
            stack_unf_q <= 1'b0;
            sp_q        <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_load_q  <= cnt_load_d;
            cnt_val_q   <= cnt_val_d;
            flush_q     <= flush_d;
            halted_q    <= halted_d;
            stack_ovf_q <= stack_ovf_d;
            stack_unf_q <= stack_unf_d;
            sp_q        <= sp_d;
        end
    end

    // NOTE: stack storage has no reset; entries above sp are never read, so their contents do not matter.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[wr_idx] <= ret_addr;
        end
    end

    assign cnt_load  = cnt_load_q;
    assign cnt_val   = cnt_val_q;
    assign flush     = flush_q;
    assign halted    = halted_q;
    assign stack_ovf = stack_ovf_q;
    assign stack_unf = stack_unf_q;
    assign sp        = sp_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed testbench for branch_ctrl (DEPTH=4); JZ expectations follow BRANCH_CTRL_JZ_EN.
module tb_branch_ctrl;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] JMP  = 3'b001;
    localparam logic [2:0] JZ   = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] pc;
    logic [7:0] instr;
    logic       instr_valid;
    logic       zero_flag;
    logic       cnt_load;
    logic [4:0] cnt_val;
    logic       flush;
    logic       halted;
    logic       stack_ovf;
    logic       stack_unf;
    logic [3:0] sp;

    int n_checks = 0;
    int n_fail   = 0;

    branch_ctrl #(.DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc         (pc),
        .instr      (instr),
        .instr_valid(instr_valid),
        .zero_flag  (zero_flag),
        .cnt_load   (cnt_load),
        .cnt_val    (cnt_val),
        .flush      (flush),
        .halted     (halted),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf),
        .sp         (sp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Apply one instruction, let one rising edge pass, then settle before sampling.
    task automatic step(input logic [4:0] p, input logic [2:0] op, input logic [4:0] tgt,
                        input logic v, input logic z);
        pc          = p;
        instr       = {op, tgt};
        instr_valid = v;
        zero_flag   = z;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        pc          = 5'd0;
        instr       = 8'd0;
        instr_valid = 1'b0;
        zero_flag   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        do_reset();
        obs = {cnt_load, cnt_val, flush, halted, stack_ovf, stack_unf};
        n_checks++;
        if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", obs, 10'd0);
        end
        n_checks++;
        if (sp !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_sp: got %0d want 0", sp);
        end
    endtask

    task automatic test_jmp();
        do_reset();
        step(5'd3, JMP, 5'h14, 1'b1, 1'b0);
        n_checks++;
        if ({cnt_load, flush} !== 2'b11 || cnt_val !== 5'h14) begin
            n_fail++;
            $display("FAIL jmp_load: got load=%b flush=%b val=%h want 1 1 14", cnt_load, flush, cnt_val);
        end
        // A branch in the FLUSH cycle must be ignored.
        step(5'd4, JMP, 5'h1F, 1'b1, 1'b0);
        n_checks++;
        if ({cnt_load, flush, halted} !== 3'b000) begin
            n_fail++;
            $display("FAIL jmp_after_flush: got load=%b flush=%b halted=%b want 0 0 0", cnt_load, flush, halted);
        end
        step(5'h14, NOP, 5'h00, 1'b1, 1'b0);
        n_checks++;
        if ({cnt_load, flush} !== 2'b00) begin
            n_fail++;
            $display("FAIL jmp_resume: got load=%b flush=%b want 0 0", cnt_load, flush);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(5'd1, JMP, 5'h08, 1'b1, 1'b0);
        step(5'd2, NOP, 5'h00, 1'b1, 1'b0);
        step(5'h08, JMP, 5'h0C, 1'b1, 1'b0);
        n_checks++;
        if (cnt_load !== 1'b1 || cnt_val !== 5'h0C) begin
            n_fail++;
            $display("FAIL b2b_second_jmp: got load=%b val=%h want 1 0c", cnt_load, cnt_val);
        end
    endtask

    task automatic test_valid_low();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(5'd7, JMP, 5'h11, 1'b0, 1'b0);
            n_checks++;
            if ({cnt_load, flush, halted} !== 3'b000 || sp !== 4'd0) begin
                n_fail++;
                $display("FAIL valid_low_hold: got load=%b flush=%b halted=%b sp=%0d want 0 0 0 0",
                         cnt_load, flush, halted, sp);
            end
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        step(5'd5, CALL, 5'h10, 1'b1, 1'b0);
        n_checks++;
        if (cnt_load !== 1'b1 || cnt_val !== 5'h10 || sp !== 4'd1) begin
            n_fail++;
            $display("FAIL call_load: got load=%b val=%h sp=%0d want 1 10 1", cnt_load, cnt_val, sp);
        end
        step(5'd6, NOP, 5'h00, 1'b1, 1'b0);
        step(5'h10, RET, 5'h00, 1'b1, 1'b0);
        n_checks++;
        if (cnt_load !== 1'b1 || cnt_val !== 5'd6 || sp !== 4'd0) begin
            n_fail++;
            $display("FAIL ret_load: got load=%b val=%h sp=%0d want 1 06 0", cnt_load, cnt_val, sp);
        end
    endtask

    task automatic test_nested();
        do_reset();
        step(5'd3, CALL, 5'h07, 1'b1, 1'b0);
        step(5'd4, NOP, 5'h00, 1'b1, 1'b0);
        step(5'd7, CALL, 5'h12, 1'b1, 1'b0);
        step(5'd8, NOP, 5'h00, 1'b1, 1'b0);
        n_checks++;
        if (sp !== 4'd2) begin
            n_fail++;
            $display("FAIL nested_sp: got %0d want 2", sp);
        end
        step(5'h12, RET, 5'h00, 1'b1, 1'b0);
        n_checks++;
        if (cnt_load !== 1'b1 || cnt_val !== 5'd8 || sp !== 4'd1) begin
            n_fail++;
            $display("FAIL nested_ret1: got load=%b val=%h sp=%0d want 1 08 1", cnt_load, cnt_val, sp);
        end
        step(5'h13, NOP, 5'h00, 1'b1, 1'b0);
        step(5'd8, RET, 5'h00, 1'b1, 1'b0);
        n_checks++;
        if (cnt_load !== 1'b1 || cnt_val !== 5'd4 || sp !== 4'd0) begin
            n_fail++;
            $display("FAIL nested_ret2: got load=%b val=%h sp=%0d want 1 04 0", cnt_load, cnt_val, sp);
        end
    endtask

    task automatic test_jz();
        logic       exp_load;
        do_reset();
        step(5'd2, JZ, 5'h08, 1'b1, 1'b0);
        n_checks++;
        if (cnt_load !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL jz_not_taken: got load=%b flush=%b want 0 0", cnt_load, flush);
        end
`ifdef BRANCH_CTRL_JZ_EN
        exp_load = 1'b1;
`else
        exp_load = 1'b0;
`endif
        step(5'd3, JZ, 5'h08, 1'b1, 1'b1);
        n_checks++;
        if (cnt_load !== exp_load || flush !== exp_load) begin
            n_fail++;
            $display("FAIL jz_zero_set: got load=%b flush=%b want %b %b", cnt_load, flush, exp_load, exp_load);
        end
        if (exp_load) begin
            n_checks++;
            if (cnt_val !== 5'h08) begin
                n_fail++;
                $display("FAIL jz_target: got %h want 08", cnt_val);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(5'(2 * i + 1), CALL, 5'(2 * i + 3), 1'b1, 1'b0);
            step(5'(2 * i + 2), NOP, 5'h00, 1'b1, 1'b0);
        end
        step(5'd9, CALL, 5'h0B, 1'b1, 1'b0);
        n_checks++;
        if (sp !== 4'd4 || stack_ovf !== 1'b1 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flags: got sp=%0d ovf=%b halted=%b want 4 1 1", sp, stack_ovf, halted);
        end
        n_checks++;
        if (cnt_load !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_no_load: got load=%b flush=%b want 0 0", cnt_load, flush);
        end
        step(5'd10, JMP, 5'h01, 1'b1, 1'b0);
        step(5'd10, RET, 5'h00, 1'b1, 1'b0);
        n_checks++;
        if (cnt_load !== 1'b0 || halted !== 1'b1 || sp !== 4'd4 || stack_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_ignores: got load=%b halted=%b sp=%0d unf=%b want 0 1 4 0",
                     cnt_load, halted, sp, stack_unf);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        step(5'd0, RET, 5'h00, 1'b1, 1'b0);
        n_checks++;
        if (stack_unf !== 1'b1 || halted !== 1'b1 || cnt_load !== 1'b0 || stack_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL unf_flags: got unf=%b halted=%b load=%b ovf=%b want 1 1 0 0",
                     stack_unf, halted, cnt_load, stack_ovf);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(5'd31, CALL, 5'h0A, 1'b1, 1'b0);
        step(5'd0, NOP, 5'h00, 1'b1, 1'b0);
        step(5'h0A, RET, 5'h00, 1'b1, 1'b0);
        n_checks++;
        if (cnt_load !== 1'b1 || cnt_val !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_ret: got load=%b val=%h want 1 00", cnt_load, cnt_val);
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        step(5'd1, CALL, 5'h1C, 1'b1, 1'b0);
        n_checks++;
        if (cnt_load !== 1'b1 || sp !== 4'd1) begin
            n_fail++;
            $display("FAIL rf_setup: got load=%b sp=%0d want 1 1", cnt_load, sp);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (cnt_load !== 1'b0 || flush !== 1'b0 || sp !== 4'd0) begin
            n_fail++;
            $display("FAIL rf_async: got load=%b flush=%b sp=%0d want 0 0 0", cnt_load, flush, sp);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(5'd2, JMP, 5'h11, 1'b1, 1'b0);
        n_checks++;
        if (cnt_load !== 1'b1 || cnt_val !== 5'h11 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL rf_resume: got load=%b val=%h halted=%b want 1 11 0", cnt_load, cnt_val, halted);
        end
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_back_to_back();
        test_valid_low();
        test_call_ret();
        test_nested();
        test_jz();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Control-flow stage paired with the program counter: it samples the instruction fetched at the current PC and decodes jump, call and return opcodes. It drives the counter's load strobe and load value, and keeps a return-address stack for subroutine calls. Non-control instructions pass untouched to the datapath; this block only steers the PC.

## Interface
Parameters:
- `DEPTH`, default 4: return-address stack entries, range 1..8.

Ports:
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `pc`  in  5  current counter value, the address of `instr`.
- `instr`  in  8  instruction at `pc`; `[7:5]` opcode, `[4:0]` target.
- `instr_valid`  in  1  `instr` is meaningful this cycle.
- `zero_flag`  in  1  ALU zero flag, already valid for the current instruction.
- `cnt_load`  out  1  one-cycle strobe to the counter's load input.
- `cnt_val`  out  5  load address, valid while `cnt_load`=1.
- `flush`  out  1  instruction present this cycle must be discarded by the datapath.
- `halted`  out  1  block is in HALT.
- `stack_ovf`  out  1  sticky: CALL issued with the stack full.
- `stack_unf`  out  1  sticky: RET issued with the stack empty.
- `sp`  out  4  number of valid stack entries, 0..DEPTH.

## Operation
Opcodes:
- 000 NOP/ALU: no action.
- 001 JMP: load target.
- 010 JZ: load target if `zero_flag`=1, otherwise no action.
- 011 CALL: push `pc+1` (5-bit, 31 wraps to 0), then load target.
- 100 RET: pop and load the popped address.
- 101 HALT: enter HALT.
- 110, 111: treated as NOP.

FSM states are RUN, FLUSH and HALT.

RUN:
- An instruction is decoded only when `instr_valid`=1.
- A taken JMP, JZ, CALL or RET registers `cnt_load`=1 and `cnt_val` for the next cycle, and moves to FLUSH.
- Opcode HALT moves to HALT.
- Everything else stays in RUN.

FLUSH:
- Lasts exactly one cycle, the cycle in which `cnt_load`=1.
- `flush`=1 and `instr` is ignored.
- Returns to RUN unconditionally.

HALT:
- `halted`=1 and `cnt_load`=0; all instructions are ignored.
- Left only by reset.

Stack:
- LIFO of DEPTH 5-bit entries.
- A push writes entry `sp`, then `sp` increments.
- A pop reads entry `sp-1`, then `sp` decrements.
- CALL with `sp`=DEPTH: no push and no load; `stack_ovf` is set and the FSM moves to HALT.
- RET with `sp`=0: no load; `stack_unf` is set and the FSM moves to HALT.

Reset values:
- `cnt_load`=0, `cnt_val`=0, `flush`=0, `halted`=0, `stack_ovf`=0, `stack_unf`=0, `sp`=0, state RUN.
- Stack contents are don't-care.

Reset mid-operation:
- Asserting reset during FLUSH or HALT returns the block to RUN immediately.
- Any pending `cnt_load` is dropped in the same cycle.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Cycle k: `pc`=A and `instr` is a taken branch, sampled at the rising edge ending cycle k.
- Cycle k+1:
  - `cnt_load`=1, `cnt_val`=T, `flush`=1.
  - The counter shows A+1; that instruction is discarded.
- Cycle k+2: `pc`=T and normal decode resumes. Branch penalty is exactly one bubble.
- Stack updates take effect at the same edge that registers `cnt_load`.
  - `sp` therefore reflects a CALL or RET from cycle k+1 onward.
- Back-to-back branches:
  - A branch arriving in the FLUSH cycle is ignored by definition.
  - The instruction at T, in cycle k+2, may itself branch.
- `instr_valid`=0 in RUN holds state; no output toggles.

## Configuration
- Macro `BRANCH_CTRL_JZ_EN`.
- Defined: opcode 010 is a conditional jump on `zero_flag`.
- Undefined:
  - Opcode 010 decodes as NOP.
  - `zero_flag` is unused and drives no logic.
  - All other behaviour is identical.

## Test plan
- Reset, then `instr`=JMP 0x14 at `pc`=3 → next cycle `cnt_load`=1, `cnt_val`=0x14, `flush`=1; following cycle `cnt_load`=0.
- CALL 0x10 at `pc`=5, then RET at `pc`=0x10 → `sp` goes 1 then 0; the RET produces `cnt_val`=6.
- With `BRANCH_CTRL_JZ_EN`:
  - JZ 0x08 with `zero_flag`=0 → no load.
  - JZ 0x08 with `zero_flag`=1 → `cnt_val`=0x08.
  - Without the macro: no load in either case.
- DEPTH=4: five nested CALLs, the fifth at `pc`=9 → `sp`=4, `stack_ovf`=1, `halted`=1, no `cnt_load`; RET on empty after reset → `stack_unf`=1, `halted`=1.
- CALL at `pc`=31 → pushed value 0, checked on the following RET (`cnt_val`=0).
- Assert `rstn`=0 in the FLUSH cycle → `cnt_load`=0 and `flush`=0 immediately, `sp`=0; after release, decoding resumes in RUN.
